// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared FSM state type and saturating-counter helpers for bpu_lvl_2
package bpu_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bpu_state_e;

  // Widest counter the helpers handle; callers zero-extend and truncate around it.
  localparam int unsigned CTR_MAX_W = 4;

  function automatic logic [CTR_MAX_W-1:0] sat_step(input logic [CTR_MAX_W-1:0] ctr,
                                                     input logic                 taken,
                                                     input int unsigned          width);
    logic [CTR_MAX_W-1:0] top;
    top = CTR_MAX_W'((1 << width) - 1);
    if (taken) return (ctr == top) ? ctr : ctr + 1'b1;
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

  function automatic logic [CTR_MAX_W-1:0] weak_not_taken(input int unsigned width);
    return CTR_MAX_W'((1 << (width - 1)) - 1);
  endfunction

endpackage

// File: rtl/bpu_sat_counter_table.sv
// rtl/bpu_sat_counter_table.sv - counter storage with sweep-init, async read and saturating update ports
module bpu_sat_counter_table
  import bpu_pkg::*;
#(
  parameter int unsigned COUNTER_W = 2,
  parameter int unsigned INDEX_W   = 4
) (
  input  logic                 clk_i,
  input  logic                 init_we_i,
  input  logic [INDEX_W-1:0]   init_addr_i,
  input  logic [INDEX_W-1:0]   rd_addr_i,
  output logic [COUNTER_W-1:0] rd_data_o,
  input  logic                 upd_we_i,
  input  logic [INDEX_W-1:0]   upd_addr_i,
  input  logic                 upd_taken_i
);

  logic [COUNTER_W-1:0] mem_q [2**INDEX_W];

  // Read is combinational so a same-cycle update is seen by the reader as the old value.
  assign rd_data_o = mem_q[rd_addr_i];

  always_ff @(posedge clk_i) begin
    if (init_we_i) begin
      mem_q[init_addr_i] <= COUNTER_W'(weak_not_taken(COUNTER_W));
    end else if (upd_we_i) begin
      mem_q[upd_addr_i] <= COUNTER_W'(sat_step(CTR_MAX_W'(mem_q[upd_addr_i]), upd_taken_i, COUNTER_W));
    end
  end

endmodule

// File: rtl/bpu_lvl_2.sv
// rtl/bpu_lvl_2.sv - two-level branch predictor; BPU_GSHARE_EN selects gshare, else bimodal indexing
module bpu_lvl_2
  import bpu_pkg::*;
#(
  parameter int unsigned COUNTER_W = 2,
  parameter int unsigned INDEX_W   = 4,
  parameter int unsigned HIST_W    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 pred_req_i,
  input  logic [INDEX_W-1:0]   pred_idx_i,
  output logic                 pred_valid_o,
  output logic                 jump_o,
  output logic [COUNTER_W-1:0] pred_counter_o,
  output logic [HIST_W-1:0]    pred_hist_o,
  input  logic                 upd_valid_i,
  input  logic [INDEX_W-1:0]   upd_idx_i,
  input  logic [HIST_W-1:0]    upd_hist_i,
  input  logic                 upd_taken_i,
  output logic                 ready_o,
  output logic [HIST_W-1:0]    ghr_o
);

  localparam logic [INDEX_W-1:0] LAST_IDX = '1;

  bpu_state_e           state_q, state_d;
  logic [INDEX_W-1:0]   ptr_q, ptr_d;
  logic [HIST_W-1:0]    ghr_q, ghr_d;
  logic [INDEX_W-1:0]   pred_eff, upd_eff;
  logic [COUNTER_W-1:0] rd_data;
  logic                 upd_en, pred_en;

  logic                 pred_valid_q;
  logic                 jump_q;
  logic [COUNTER_W-1:0] pred_counter_q;
  logic [HIST_W-1:0]    pred_hist_q;

`ifdef BPU_GSHARE_EN
  logic [HIST_W:0] hist_shift;
  assign hist_shift = {ghr_q, upd_taken_i};
  assign pred_eff   = pred_idx_i ^ INDEX_W'(ghr_q);
  assign upd_eff    = upd_idx_i ^ INDEX_W'(upd_hist_i);
`else
  logic unused_hist;
  assign unused_hist = ^upd_hist_i;
  assign pred_eff    = pred_idx_i;
  assign upd_eff     = upd_idx_i;
`endif

  // Clear wins over an update in the same cycle; updates are dropped while sweeping.
  assign upd_en  = (state_q == RUN) && upd_valid_i && !clear_i;
  assign pred_en = (state_q == RUN) && pred_req_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ghr_d   = ghr_q;
    if (clear_i) begin
      state_d = INIT;
      ptr_d   = '0;
      ghr_d   = '0;
    end else if (state_q == INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST_IDX) state_d = RUN;
    end else if (upd_valid_i) begin
`ifdef BPU_GSHARE_EN
      ghr_d = hist_shift[HIST_W-1:0];
`else
      ghr_d = '0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= INIT;
      ptr_q          <= '0;
      ghr_q          <= '0;
      pred_valid_q   <= 1'b0;
      jump_q         <= 1'b0;
      pred_counter_q <= '0;
      pred_hist_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_en;
      if (pred_en) begin
        jump_q         <= rd_data[COUNTER_W-1];
        pred_counter_q <= rd_data;
        pred_hist_q    <= ghr_q;
      end
    end
  end

  bpu_sat_counter_table #(
    .COUNTER_W (COUNTER_W),
    .INDEX_W   (INDEX_W)
  ) u_table (
    .clk_i       (clk_i),
    .init_we_i   (state_q == INIT),
    .init_addr_i (ptr_q),
    .rd_addr_i   (pred_eff),
    .rd_data_o   (rd_data),
    .upd_we_i    (upd_en),
    .upd_addr_i  (upd_eff),
    .upd_taken_i (upd_taken_i)
  );

  assign pred_valid_o   = pred_valid_q;
  assign jump_o         = jump_q;
  assign pred_counter_o = pred_counter_q;
  assign pred_hist_o    = pred_hist_q;
  assign ready_o        = (state_q == RUN);
  assign ghr_o          = ghr_q;

endmodule
